rvv_vcfg_unit: RTL and testbench

Parametrised vector-configuration unit that executes vsetvli, vsetivli and vsetvl and owns the architectural vl and vtype CSRs. It generalises the fixed 128-bit, 7-bit-vl configuration to any VLEN and ELEN, and adds full RVV 1.0 vill detection, the rs1/rd-zero AVL rules and fractional LMUL. It sits between vid, which issues requests, and vex/vlsu, which consume vl and vtype. It also honours the ctrl hold line and pipeline flush.

---
 rtl/rvv_vcfg_unit.sv | 169 ++++++++++++++++
 tb/tb_rvv_vcfg_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rvv_vcfg_unit.sv
// rvv_vcfg_unit: executes vsetvli / vsetivli / vsetvl and owns the
// architectural vl and vtype CSRs. It is a three-state FSM (IDLE, CALC, RESP):
// a request is latched in IDLE, decoded and committed in CALC, and its rd
// result is presented in RESP. All outputs are registers, so consumers never
// see combinational glitches on vl or vtype.
module rvv_vcfg_unit #(
  parameter int VLEN = 128,
  parameter int ELEN = 32,
  parameter int XLEN = 32,
  parameter int VLW  = $clog2(VLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_kind,
  input  logic            rs1_is_x0,
  input  logic            rd_is_x0,
  input  logic [XLEN-1:0] avl_in,
  input  logic [XLEN-1:0] vtype_in,
  input  logic            hold,
  input  logic            flush,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_vl,
  output logic [VLW-1:0]  vl,
  output logic [2:0]      vsew,
  output logic [2:0]      vlmul,
  output logic            vta,
  output logic            vma,
  output logic            vill,
  output logic            busy
);

  // Largest legal vsew encoding: SEW = 8 << vsew must not exceed ELEN.
  localparam logic [3:0]     MAX_VSEW = 4'($clog2(ELEN / 8));
  localparam logic [VLW-1:0] VLEN_V   = VLW'(VLEN);
  localparam logic [1:0]     K_VSETIVLI = 2'b01;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  state_t state;

  // Request captured at the IDLE handshake; decode works only from these.
  logic [1:0]      kind_q;
  logic            rs1_x0_q;
  logic            rd_x0_q;
  logic [XLEN-1:0] avl_q;
  logic [XLEN-1:0] vtype_q;

  // vtype field decode of the latched operand.
  logic [2:0] n_vsew;
  logic [2:0] n_vlmul;
  logic       n_vta;
  logic       n_vma;
  logic       lmul_frac;
  logic [2:0] frac_sh;
  assign n_vsew    = vtype_q[5:3];
  assign n_vlmul   = vtype_q[2:0];
  assign n_vta     = vtype_q[6];
  assign n_vma     = vtype_q[7];
  assign lmul_frac = n_vlmul[2];
  // 8 - vlmul in 3 bits: 111->1 (1/2), 110->2 (1/4), 101->3 (1/8).
  assign frac_sh   = 3'd0 - n_vlmul;

  // vill covers unsupported SEW, reserved LMUL, fractional LMUL too small
  // for SEW (SEW > ELEN*LMUL <=> vsew + log2(1/LMUL) > log2(ELEN/8)),
  // and any nonzero bit above vma, including the vill bit itself.
  logic vill_c;
  assign vill_c = ({1'b0, n_vsew} > MAX_VSEW)
                | (n_vlmul == 3'b100)
                | (lmul_frac && (({1'b0, n_vsew} + {1'b0, frac_sh}) > MAX_VSEW))
                | (|vtype_q[XLEN-1:8]);

  // VLMAX = (VLEN / SEW) * LMUL, built from shifts only.
  logic [VLW-1:0]  vlmax_base;
  logic [VLW-1:0]  vlmax;
  logic [XLEN-1:0] vlmax_x;
  assign vlmax_base = VLEN_V >> ({1'b0, n_vsew} + 4'd3);
  assign vlmax      = lmul_frac ? (vlmax_base >> frac_sh) : (vlmax_base << n_vlmul[1:0]);
  assign vlmax_x    = XLEN'(vlmax);

  // New vl selection; AVL is compared at full XLEN so large AVLs clamp.
  logic [VLW-1:0] nvl;
  always_comb begin
    nvl = '0;
    if (vill_c)
      nvl = '0;
    else if (kind_q == K_VSETIVLI)
      nvl = (avl_q < vlmax_x) ? avl_q[VLW-1:0] : vlmax;
    else if (rs1_x0_q && !rd_x0_q)
      nvl = vlmax;
    else if (rs1_x0_q)
      nvl = (vl < vlmax) ? vl : vlmax;
    else
      nvl = (avl_q < vlmax_x) ? avl_q[VLW-1:0] : vlmax;
  end

  // Control FSM with registered handshake, response and CSR outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_vl    <= '0;
      kind_q    <= '0;
      rs1_x0_q  <= 1'b0;
      rd_x0_q   <= 1'b0;
      avl_q     <= '0;
      vtype_q   <= '0;
      vl        <= '0;
      vsew      <= '0;
      vlmul     <= '0;
      vta       <= 1'b0;
      vma       <= 1'b0;
      vill      <= 1'b1;
    end else begin
      case (state)
        // Flush is meaningless here; a concurrent request is still taken.
        IDLE: begin
          if (req_valid && req_ready) begin
            kind_q    <= req_kind;
            rs1_x0_q  <= rs1_is_x0;
            rd_x0_q   <= rd_is_x0;
            avl_q     <= avl_in;
            vtype_q   <= vtype_in;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= CALC;
          end
        end
        // Flush beats hold; hold simply re-evaluates next cycle.
        CALC: begin
          if (flush) begin
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (!hold) begin
            vl        <= nvl;
            vill      <= vill_c;
            vsew      <= vill_c ? 3'b000 : n_vsew;
            vlmul     <= vill_c ? 3'b000 : n_vlmul;
            vta       <= vill_c ? 1'b0   : n_vta;
            vma       <= vill_c ? 1'b0   : n_vma;
            rsp_vl    <= XLEN'(nvl);
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        // CSRs are already committed; only the rd handshake remains.
        RESP: begin
          if (flush || rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rvv_vcfg_unit.sv
// Directed bench for rvv_vcfg_unit at VLEN=128, ELEN=32, XLEN=32.
module tb_rvv_vcfg_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_kind = 2'b00;
  logic        rs1_is_x0 = 1'b0;
  logic        rd_is_x0 = 1'b0;
  logic [31:0] avl_in = '0;
  logic [31:0] vtype_in = '0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_vl;
  logic [7:0]  vl;
  logic [2:0]  vsew;
  logic [2:0]  vlmul;
  logic        vta;
  logic        vma;
  logic        vill;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;

  rvv_vcfg_unit #(.VLEN(128), .ELEN(32), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_kind(req_kind), .rs1_is_x0(rs1_is_x0), .rd_is_x0(rd_is_x0),
    .avl_in(avl_in), .vtype_in(vtype_in), .hold(hold), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_vl(rsp_vl),
    .vl(vl), .vsew(vsew), .vlmul(vlmul), .vta(vta), .vma(vma),
    .vill(vill), .busy(busy)
  );

  always #5 clk = ~clk;

  // vtype field packing: {vma, vta, vsew[2:0], vlmul[2:0]}
  function automatic logic [31:0] vt(input logic [2:0] s, input logic [2:0] m);
    return {26'd0, s, m};
  endfunction

  // Present a request for one edge; returns #1 after the accepting edge.
  task automatic send(input logic [1:0] k, input logic r1, input logic rd,
                      input logic [31:0] a, input logic [31:0] t);
    req_valid = 1'b1; req_kind = k; rs1_is_x0 = r1; rd_is_x0 = rd;
    avl_in = a; vtype_in = t;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Request plus the commit edge; returns in RESP.
  task automatic run_op(input logic [1:0] k, input logic r1, input logic rd,
                        input logic [31:0] a, input logic [31:0] t);
    send(k, r1, rd, a, t);
    @(posedge clk); #1;
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_total++; if (vl !== 8'd0) $display("FAIL reset_vl got %0d exp 0", vl); else n_pass++;
    n_total++; if (vill !== 1'b1) $display("FAIL reset_vill got %0b exp 1", vill); else n_pass++;
    n_total++; if ({vsew, vlmul, vta, vma} !== 8'd0) $display("FAIL reset_vtype got %h exp 0", {vsew, vlmul, vta, vma}); else n_pass++;
    n_total++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL reset_rsp_busy got %b exp 00", {rsp_valid, busy}); else n_pass++;
    n_total++; if (rsp_vl !== 32'd0) $display("FAIL reset_rsp_vl got %0d exp 0", rsp_vl); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %0b exp 1", req_ready); else n_pass++;
  endtask

  task automatic test_vsetvli_basic();
    send(2'b00, 1'b0, 1'b0, 32'd200, vt(3'd0, 3'd0));
    n_total++; if ({busy, req_ready, rsp_valid} !== 3'b100) $display("FAIL basic_calc_flags got %b exp 100", {busy, req_ready, rsp_valid}); else n_pass++;
    n_total++; if (vl !== 8'd0) $display("FAIL basic_vl_before_commit got %0d exp 0", vl); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (rsp_valid !== 1'b1) $display("FAIL basic_rsp_valid got %0b exp 1", rsp_valid); else n_pass++;
    n_total++; if (vl !== 8'd16) $display("FAIL basic_vl got %0d exp 16", vl); else n_pass++;
    n_total++; if (rsp_vl !== 32'd16) $display("FAIL basic_rsp_vl got %0d exp 16", rsp_vl); else n_pass++;
    n_total++; if (vill !== 1'b0) $display("FAIL basic_vill got %0b exp 0", vill); else n_pass++;
    // rsp holds steady while the consumer stalls
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_total++; if ({rsp_valid, rsp_vl} !== {1'b1, 32'd16}) $display("FAIL basic_rsp_stable got %0b/%0d exp 1/16", rsp_valid, rsp_vl); else n_pass++;
    ack();
    n_total++; if ({busy, req_ready, rsp_valid} !== 3'b010) $display("FAIL basic_idle_flags got %b exp 010", {busy, req_ready, rsp_valid}); else n_pass++;
  endtask

  task automatic test_vlmax_and_frac();
    run_op(2'b00, 1'b1, 1'b0, 32'd0, vt(3'd2, 3'd3));
    n_total++; if (vl !== 8'd32) $display("FAIL vlmax_x0_vl got %0d exp 32", vl); else n_pass++;
    n_total++; if ({vsew, vlmul} !== 6'b010_011) $display("FAIL vlmax_x0_vtype got %b exp 010011", {vsew, vlmul}); else n_pass++;
    ack();
    run_op(2'b00, 1'b0, 1'b0, 32'd5, vt(3'd0, 3'd7));
    n_total++; if ({vill, vl} !== {1'b0, 8'd5}) $display("FAIL frac_half got %0b/%0d exp 0/5", vill, vl); else n_pass++;
    ack();
    run_op(2'b00, 1'b0, 1'b0, 32'd5, vt(3'd2, 3'd5));
    n_total++; if ({vill, vl} !== {1'b1, 8'd0}) $display("FAIL frac_vill got %0b/%0d exp 1/0", vill, vl); else n_pass++;
    n_total++; if ({vsew, vlmul, vta, vma} !== 8'd0) $display("FAIL frac_vill_vtype got %h exp 0", {vsew, vlmul, vta, vma}); else n_pass++;
    ack();
  endtask

  task automatic test_vill_cases();
    run_op(2'b00, 1'b0, 1'b0, 32'd4, vt(3'd3, 3'd0));
    n_total++; if ({vill, vl} !== {1'b1, 8'd0}) $display("FAIL vill_sew64 got %0b/%0d exp 1/0", vill, vl); else n_pass++;
    ack();
    run_op(2'b00, 1'b0, 1'b0, 32'd4, vt(3'd0, 3'd4));
    n_total++; if (vill !== 1'b1) $display("FAIL vill_lmul100 got %0b exp 1", vill); else n_pass++;
    ack();
    run_op(2'b10, 1'b0, 1'b0, 32'd4, 32'h8000_0000);
    n_total++; if (vill !== 1'b1) $display("FAIL vill_bit31 got %0b exp 1", vill); else n_pass++;
    ack();
    run_op(2'b10, 1'b0, 1'b0, 32'd4, 32'h0000_0100);
    n_total++; if (vill !== 1'b1) $display("FAIL vill_reserved got %0b exp 1", vill); else n_pass++;
    ack();
    // 261 truncated to 8 bits would be 5; full-width compare clamps to 16
    run_op(2'b10, 1'b0, 1'b0, 32'd261, vt(3'd0, 3'd0));
    n_total++; if ({vill, vl} !== {1'b0, 8'd16}) $display("FAIL vsetvl_wide_avl got %0b/%0d exp 0/16", vill, vl); else n_pass++;
    ack();
  endtask

  task automatic test_vsetivli_keep();
    run_op(2'b01, 1'b1, 1'b0, 32'd31, vt(3'd1, 3'd1));
    n_total++; if (vl !== 8'd16) $display("FAIL ivli_vl got %0d exp 16", vl); else n_pass++;
    ack();
    run_op(2'b00, 1'b1, 1'b1, 32'd0, vt(3'd1, 3'd0));
    n_total++; if ({rsp_vl[7:0], vl} !== {8'd8, 8'd8}) $display("FAIL keep_vl got %0d/%0d exp 8/8", rsp_vl, vl); else n_pass++;
    ack();
  endtask

  task automatic test_hold_flush();
    hold = 1'b1;
    send(2'b00, 1'b0, 1'b0, 32'd3, 32'h0000_00C0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_total++; if ({rsp_valid, busy, vl} !== {1'b0, 1'b1, 8'd8}) $display("FAIL hold_cycle%0d got %0b/%0b/%0d exp 0/1/8", i, rsp_valid, busy, vl); else n_pass++;
    end
    hold = 1'b0;
    @(posedge clk); #1;
    n_total++; if ({rsp_valid, vl, vta, vma} !== {1'b1, 8'd3, 1'b1, 1'b1}) $display("FAIL hold_release got %0b/%0d/%0b%0b exp 1/3/11", rsp_valid, vl, vta, vma); else n_pass++;
    ack();
    hold = 1'b1;
    send(2'b00, 1'b0, 1'b0, 32'd7, vt(3'd0, 3'd0));
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; hold = 1'b0;
    n_total++; if ({busy, req_ready, rsp_valid, vl} !== {3'b010, 8'd3}) $display("FAIL flush_hold got %b/%0d exp 010/3", {busy, req_ready, rsp_valid}, vl); else n_pass++;
    // flush in RESP drops the response but keeps the commit
    run_op(2'b00, 1'b0, 1'b0, 32'd9, vt(3'd0, 3'd0));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_total++; if ({busy, rsp_valid, vl} !== {2'b00, 8'd9}) $display("FAIL flush_resp got %b/%0d exp 00/9", {busy, rsp_valid}, vl); else n_pass++;
    // flush in IDLE does not block an arriving request
    flush = 1'b1;
    send(2'b00, 1'b0, 1'b0, 32'd5, vt(3'd0, 3'd0));
    flush = 1'b0;
    @(posedge clk); #1;
    n_total++; if ({rsp_valid, vl} !== {1'b1, 8'd5}) $display("FAIL flush_idle got %0b/%0d exp 1/5", rsp_valid, vl); else n_pass++;
    ack();
  endtask

  task automatic test_async_reset();
    run_op(2'b00, 1'b0, 1'b0, 32'd12, vt(3'd0, 3'd0));
    #2;
    rst = 1'b1;
    #1;
    n_total++; if ({rsp_valid, vill, vl, busy} !== {1'b0, 1'b1, 8'd0, 1'b0}) $display("FAIL async_rst got %0b/%0b/%0d/%0b exp 0/1/0/0", rsp_valid, vill, vl, busy); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(2'b00, 1'b0, 1'b0, 32'd6, vt(3'd0, 3'd0));
    n_total++; if ({rsp_valid, vl, vill} !== {1'b1, 8'd6, 1'b0}) $display("FAIL after_rst got %0b/%0d/%0b exp 1/6/0", rsp_valid, vl, vill); else n_pass++;
    ack();
  endtask

  initial begin
    test_reset();
    test_vsetvli_basic();
    test_vlmax_and_frac();
    test_vill_cases();
    test_vsetivli_keep();
    test_hold_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
